// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// A start/done handshake frames each WIDTH-cycle conversion.
module bcd_seq_conv #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned WW = BW + WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Reject operand widths or digit counts that cannot hold the largest input.
    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("bcd_seq_conv: WIDTH must be in 4..16");
    end
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
        $error("bcd_seq_conv: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [WW-1:0]   work_q,  work_d;
    logic [BW-1:0]   bcd_q,   bcd_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [WW-1:0]   fixed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fixed   = work_q;

        // Digit correction: each BCD field >= 5 gets +3 before the shift, no inter-digit carry.
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work_q[WIDTH + 4*i +: 4] >= 4'd5) begin
                fixed[WIDTH + 4*i +: 4] = work_q[WIDTH + 4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    work_d  = {{BW{1'b0}}, bin};
                    cnt_d   = CW'(WIDTH);
                    state_d = CONV;
                    busy_d  = 1'b1;
                end
            end
            CONV: begin
                work_d = fixed << 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    bcd_d   = work_d[WW-1 -: BW];
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule
